weight_stream_gen: RTL

Parametrised multi-channel weight stream generator for the convolution accelerator's weight-buffer load path. On a start command it emits a burst of NUM_CH parallel weight words per beat over a valid/ready handshake, with selectable data modes: per-channel LFSR pseudo-random, incrementing, constant, or per-channel ramp. It is synthesizable, uses no $urandom, and is usable both as bench stimulus and as an on-chip self-test source for the weight buffer and PE array.

---
 rtl/wgen_pkg.sv | 20 ++
 rtl/weight_stream_gen_if.sv | 13 +
 rtl/wgen_lfsr.sv | 26 ++
 rtl/weight_stream_gen.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/wgen_pkg.sv
// Shared types and constants for the weight stream generator.
package wgen_pkg;

  typedef enum logic [1:0] {
    WGEN_LFSR  = 2'd0,
    WGEN_INCR  = 2'd1,
    WGEN_CONST = 2'd2,
    WGEN_RAMP  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [15:0] WGEN_DEF_TAPS = 16'hB400;

endpackage

// File: rtl/weight_stream_gen_if.sv
// Valid/ready beat stream carrying NUM_CH packed weight words per beat.
interface weight_stream_gen_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4
) ();
  logic                         out_valid;
  logic                         out_ready;
  logic                         out_last;
  logic [NUM_CH*DATA_WIDTH-1:0] out_data;

  modport master (output out_valid, out_data, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/wgen_lfsr.sv
// Per-channel Galois LFSR; a zero seed is forced to 1 so the register never locks up.
module wgen_lfsr
  import wgen_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] TAPS       = DATA_WIDTH'(WGEN_DEF_TAPS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] seed_in,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] value
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      value <= '0;
    end else if (load) begin
      value <= (seed_in == '0) ? DATA_WIDTH'(1) : seed_in;
    end else if (advance) begin
      value <= (value >> 1) ^ (value[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/weight_stream_gen.sv
// Multi-channel weight burst generator (LFSR / INCR / CONST / RAMP) on a valid/ready stream.
// Optional macro WGEN_CHECKSUM_EN adds an XOR checksum of every accepted channel word.
//
// state  | meaning
// IDLE   | waiting for start; configuration latched on accept
// LOAD   | seeding per-channel generators, beat counter cleared
// STREAM | presenting beats; advance on valid && ready
// DONE   | burst finished; busy drops and done pulses on the following cycle
module weight_stream_gen
  import wgen_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    NUM_CH     = 4,
  parameter int                    MAX_BURST  = 1024,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(WGEN_DEF_TAPS),
  localparam int                   CNT_W      = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [CNT_W-1:0]      burst_len,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [DATA_WIDTH-1:0] const_val,
  weight_stream_gen_if.master   strm,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      beat_cnt
`ifdef WGEN_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  state_e                       state, state_nx;
  mode_e                        mode_q;
  logic [CNT_W-1:0]             len_q;
  logic [DATA_WIDTH-1:0]        seed_q, const_q;
  logic [DATA_WIDTH-1:0]        lfsr_val  [NUM_CH];
  logic [DATA_WIDTH-1:0]        chan_word [NUM_CH];
  logic [NUM_CH*DATA_WIDTH-1:0] data_bus;
  logic [DATA_WIDTH-1:0]        b_word;
  logic                         accept, is_last, start_ok;

  assign start_ok       = (state == IDLE) && start;
  assign strm.out_valid = (state == STREAM);
  assign accept         = strm.out_valid && strm.out_ready;
  assign is_last        = (beat_cnt == len_q - CNT_W'(1));
  assign strm.out_last  = strm.out_valid && is_last;
  assign strm.out_data  = data_bus;
  assign b_word         = DATA_WIDTH'(beat_cnt);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (burst_len == '0) ? DONE : LOAD;
      LOAD:    state_nx = STREAM;
      STREAM:  if (accept && is_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // busy/done are registered, so they trail the state register by one cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q   <= WGEN_LFSR;
      len_q    <= '0;
      seed_q   <= '0;
      const_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      beat_cnt <= '0;
    end else begin
      done <= (state == DONE);
      if (start_ok) begin
        mode_q   <= mode_e'(mode);
        len_q    <= burst_len;
        seed_q   <= seed;
        const_q  <= const_val;
        busy     <= 1'b1;
        beat_cnt <= '0;
      end else if (state == DONE) begin
        busy <= 1'b0;
      end
      if (state == LOAD)  beat_cnt <= '0;
      else if (accept)    beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    wgen_lfsr #(.DATA_WIDTH(DATA_WIDTH), .TAPS(LFSR_TAPS)) u_lfsr (
      .clk     (clk),
      .rstn    (rstn),
      .load    (state == LOAD),
      .seed_in (seed_q ^ DATA_WIDTH'(c)),
      .advance (accept),
      .value   (lfsr_val[c])
    );
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      chan_word[c] = '0;
      case (mode_q)
        WGEN_LFSR:  chan_word[c] = lfsr_val[c];
        WGEN_INCR:  chan_word[c] = b_word;
        WGEN_CONST: chan_word[c] = const_q;
        WGEN_RAMP:  chan_word[c] = b_word + DATA_WIDTH'(c);
        default:    chan_word[c] = '0;
      endcase
    end
  end

  always_comb begin
    data_bus = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      data_bus[c*DATA_WIDTH +: DATA_WIDTH] = strm.out_valid ? chan_word[c] : '0;
    end
  end

`ifdef WGEN_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] beat_xor;

  always_comb begin
    beat_xor = '0;
    for (int c = 0; c < NUM_CH; c++) beat_xor ^= chan_word[c];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         checksum <= '0;
    else if (start_ok) checksum <= '0;
    else if (accept)   checksum <= checksum ^ beat_xor;
  end
`endif

endmodule
